// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU multiply sequencer and the team ALU:
// controller state encoding, ALU operation codes and step count.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS);

endpackage

// File: rtl/alu.sv
// Team ALU: ripple-carry adder with AND/OR/ADD operations.
// Ports:
//   a, b       operands
//   binvert    invert b before the operation (subtract with carryin=1)
//   carryin    carry into bit 0
//   operation  OP_AND / OP_OR / OP_ADD; other codes give zero
//   result     operation result
//   carryout   carry out of the MSB
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             binvert,
    input  logic             carryin,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             carryout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             ripple;

    assign b_eff = b ^ {WIDTH{binvert}};

    // Bit-serial ripple carry chain.
    always_comb begin
        sum    = '0;
        ripple = carryin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ ripple;
            ripple = (a[i] & b_eff[i]) | (ripple & (a[i] ^ b_eff[i]));
        end
        carryout = ripple;
    end

    // Operation select.
    always_comb begin
        result = '0;
        case (operation)
            OP_AND:  result = a & b_eff;
            OP_OR:   result = a | b_eff;
            OP_ADD:  result = sum;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mul_step.sv
// One shift-add step of the multiplier: recovers the carry out of the ALU
// sum from the operand and result sign bits, then shifts {c, s, lo} right.
// Ports:
//   hi        current upper half of the partial product (ALU operand a)
//   lo_shift  current lower half without bit 0 (bit 0 only selects b)
//   b         addend presented to the ALU (multiplicand or zero)
//   s         ALU sum hi + b
//   hi_next   next upper half
//   lo_next   next lower half
module mul_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:1] lo_shift,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic carry;

    // Carry out of an unsigned add: both MSBs set, or one set and the sum MSB cleared.
    assign carry = (hi[WIDTH-1] & b[WIDTH-1]) |
                   ((hi[WIDTH-1] | b[WIDTH-1]) & ~s[WIDTH-1]);

    assign hi_next = {carry, s[WIDTH-1:1]};
    assign lo_next = {s[0], lo_shift};

endmodule

// File: rtl/alu_mul_ctrl.sv
// Multi-cycle unsigned WIDTHxWIDTH -> 2*WIDTH multiplier that borrows the
// shared ALU for one shift-add step per clock.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               request, sampled only when idle
//   mcand, mplier       operands, captured on the accepting edge
//   busy                high while iterating
//   done                one-cycle pulse when product is valid
//   product             {hi, lo}; final from done until the next accept
//   alu_a, alu_b        ALU operands (zero when not iterating)
//   alu_binvert         tied 0
//   alu_carryin         tied 0
//   alu_op              OP_ADD while iterating, OP_AND otherwise
//   alu_result          ALU result (sum hi + alu_b)
module alu_mul_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_binvert,
    output logic               alu_carryin,
    output logic [1:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] hi, hi_nx;
    logic [WIDTH-1:0] lo, lo_nx;
    logic [WIDTH-1:0] mc, mc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             busy_nx, done_nx;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign alu_binvert = 1'b0;
    assign alu_carryin = 1'b0;
    assign product     = {hi, lo};

    // ALU drive: operands only while iterating, released otherwise.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_AND;
        if (state == ITER) begin
            alu_a  = hi;
            alu_b  = mc & {WIDTH{lo[0]}};
            alu_op = OP_ADD;
        end
    end

    mul_step #(
        .WIDTH (WIDTH)
    ) u_mul_step (
        .hi       (hi),
        .lo_shift (lo[WIDTH-1:1]),
        .b        (alu_b),
        .s        (alu_result),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            mc    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            mc    <= mc_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_nx = state;
        hi_nx    = hi;
        lo_nx    = lo;
        mc_nx    = mc;
        cnt_nx   = cnt;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ITER;
                    mc_nx    = mcand;
                    hi_nx    = '0;
                    lo_nx    = mplier;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            ITER: begin
                hi_nx  = step_hi;
                lo_nx  = step_lo;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    busy_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_ctrl.sv
module tb_alu_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic        busy, done;
    logic [63:0] product;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_binvert, alu_carryin, alu_cout;
    logic [1:0]  alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mcand       (mcand),
        .mplier      (mplier),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_binvert (alu_binvert),
        .alu_carryin (alu_carryin),
        .alu_op      (alu_op),
        .alu_result  (alu_result)
    );

    alu u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .binvert   (alu_binvert),
        .carryin   (alu_carryin),
        .operation (alu_op),
        .result    (alu_result),
        .carryout  (alu_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // ALU control must be released unless the sequencer is expected busy.
    task automatic check_alu_ctl(input bit exp_busy);
        check("alu_op", 64'(alu_op), exp_busy ? 64'd2 : 64'd0);
        check("alu_binvert", 64'(alu_binvert), 64'd0);
        check("alu_carryin", 64'(alu_carryin), 64'd0);
        if (!exp_busy) begin
            check("alu_a_idle", 64'(alu_a), 64'd0);
            check("alu_b_idle", 64'(alu_b), 64'd0);
        end
    endtask

    // One multiply with a single-cycle start and a fixed expected timeline.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int busy_cnt;
        exp = ref_mul(a, b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        busy_cnt = 0;
        for (int n = 1; n <= 33; n++) begin
            check("busy", 64'(busy), (n <= 32) ? 64'd1 : 64'd0);
            check("done", 64'(done), (n == 33) ? 64'd1 : 64'd0);
            check_alu_ctl(n <= 32);
            if (busy) busy_cnt++;
            if (n == 33) check("product", product, exp);
            if (n < 33) @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'd32);
        @(negedge clk);
        check("done_pulse_end", 64'(done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("product_held", product, exp);
    endtask

    logic [31:0] ha [0:200];
    logic [31:0] hb [0:200];

    initial begin
        // Reset state.
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check_alu_ctl(1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_mul(32'd3, 32'd5);
        check("p_3x5", product, 64'h0000_0000_0000_000F);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("p_max", product, 64'hFFFF_FFFE_0000_0001);
        do_mul(32'd0, 32'hA5A5_A5A5);
        check("p_zero", product, 64'd0);
        do_mul(32'h5A5A_5A5A, 32'd1);
        check("p_one", product, 64'h0000_0000_5A5A_5A5A);

        // start held high with operands changing every cycle.
        begin
            int last_done;
            int ndone;
            last_done = -1;
            ndone = 0;
            start = 1'b1;
            for (int c = 0; c <= 140; c++) begin
                if (c > 0) @(negedge clk);
                if (done) begin
                    ndone++;
                    if (c >= 33) check("hold_product", product, ref_mul(ha[c-33], hb[c-33]));
                    else check("hold_early_done", 64'(c), 64'd33);
                    if (last_done >= 0) check("hold_spacing", 64'(c - last_done), 64'd34);
                    last_done = c;
                end
                ha[c]  = $urandom;
                hb[c]  = $urandom;
                mcand  = ha[c];
                mplier = hb[c];
            end
            start = 1'b0;
            check("hold_ndone", 64'(ndone), 64'd4);
            repeat (40) @(negedge clk);
            check("hold_idle", 64'(busy), 64'd0);
        end

        // Asynchronous reset in the middle of iteration.
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'h1234_5678;
        mplier = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_product", product, 64'd0);
        check_alu_ctl(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("arst_hold_product", product, 64'd0);
        rst = 1'b0;
        do_mul(32'hDEAD_BEEF, 32'h0BAD_F00D);

        // Random pairs with occasional extreme operands.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'd0;
                3: b = 32'h8000_0000;
                default: ;
            endcase
            do_mul(a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
